// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: finds full rows of a landed board, blinks them, then collapses the board
// and publishes it on board_out with a one-cycle done pulse.
module line_clear_ctrl #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int FLASH_FRAMES = 30,
    parameter int BLINK_FRAMES = 5
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [ROWS*COLS-1:0] flash,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(FLASH_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, SCAN, FLASH, COLLAPSE, ZERO, DONE} state_t;

    state_t          r_state, w_next;
    logic [N-1:0]    r_work, r_new, w_flash_mask;
    logic [ROWS-1:0] r_full, w_full;
    logic [4:0]      w_cnt;
    logic [RW-1:0]   r_src, r_wptr;
    logic [TW-1:0]   r_ticks;
    logic [BW-1:0]   r_blink;
    logic            r_phase;
    logic            w_blink_wrap;

    always_comb begin
        w_cnt = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_full[r] = &r_work[r*COLS +: COLS];
            w_cnt = w_cnt + 5'(w_full[r]);
        end
    end

    always_comb begin
        w_flash_mask = '0;
        for (int r = 0; r < ROWS; r++)
            w_flash_mask[r*COLS +: COLS] = {COLS{r_full[r]}};
    end

    assign w_blink_wrap = r_blink == BW'(BLINK_FRAMES - 1);

    always_ff @(posedge clk) begin
        if (clr)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = start ? SCAN : IDLE;
            SCAN:     w_next = (w_full == '0) ? DONE : FLASH;
            FLASH:    w_next = (frame_tick && r_ticks == TW'(FLASH_FRAMES - 1)) ? COLLAPSE : FLASH;
            COLLAPSE: w_next = (r_src == '0) ? ZERO : COLLAPSE;
            ZERO:     w_next = (r_wptr == '0) ? DONE : ZERO;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = r_state != IDLE;
        flash = (r_state == FLASH && r_phase) ? w_flash_mask : '0;
    end

    // done is registered so it coincides with board_out already holding the result
    always_ff @(posedge clk) begin
        if (clr) begin
            r_work        <= '0;
            r_new         <= '0;
            board_out     <= '0;
            r_full        <= '0;
            lines_cleared <= '0;
            r_src         <= '0;
            r_wptr        <= '0;
            r_ticks       <= '0;
            r_blink       <= '0;
            r_phase       <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= r_state == DONE;
            case (r_state)
                IDLE: if (start) r_work <= board_in;
                SCAN: begin
                    r_full        <= w_full;
                    lines_cleared <= w_cnt;
                    r_ticks       <= '0;
                    r_blink       <= '0;
                    r_phase       <= 1'b1;
                    r_src         <= RW'(ROWS - 1);
                    r_wptr        <= RW'(ROWS - 1);
                end
                FLASH: if (frame_tick) begin
                    r_ticks <= r_ticks + 1'b1;
                    r_blink <= w_blink_wrap ? '0 : r_blink + 1'b1;
                    if (w_blink_wrap) r_phase <= ~r_phase;
                end
                COLLAPSE: begin
                    if (!r_full[r_src]) begin
                        r_new[r_wptr*COLS +: COLS] <= r_work[r_src*COLS +: COLS];
                        r_wptr <= r_wptr - 1'b1;
                    end
                    if (r_src != '0) r_src <= r_src - 1'b1;
                end
                ZERO: begin
                    r_new[r_wptr*COLS +: COLS] <= '0;
                    if (r_wptr != '0) r_wptr <= r_wptr - 1'b1;
                end
                DONE: board_out <= (lines_cleared == '0) ? r_work : r_new;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: randomized scenarios checked against a row-list model of line clearing.
module tb_line_clear_ctrl;
    localparam int R = 20;
    localparam int C = 10;
    localparam int N = R * C;

    logic         clk = 1'b0;
    logic         clr, frame_tick, start;
    logic [N-1:0] board_in, board_out, flash;
    logic         busy, done;
    logic [4:0]   lines_cleared;
    int           total = 0;
    int           bad = 0;

    line_clear_ctrl dut (
        .clk(clk), .clr(clr), .frame_tick(frame_tick), .start(start), .board_in(board_in),
        .board_out(board_out), .flash(flash), .busy(busy), .done(done),
        .lines_cleared(lines_cleared)
    );

    always #20 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int model_full_cnt(input logic [N-1:0] b);
        int n = 0;
        for (int r = 0; r < R; r++) if (&b[r*C +: C]) n++;
        return n;
    endfunction

    function automatic logic [N-1:0] model_full_bits(input logic [N-1:0] b);
        logic [N-1:0] m = '0;
        for (int r = 0; r < R; r++) if (&b[r*C +: C]) m[r*C +: C] = '1;
        return m;
    endfunction

    // surviving rows stacked from the bottom in their original order, empty rows on top
    function automatic logic [N-1:0] model_collapse(input logic [N-1:0] b);
        logic [C-1:0] keep[$];
        logic [N-1:0] o = '0;
        int w = R - 1;
        for (int r = R - 1; r >= 0; r--) if (!(&b[r*C +: C])) keep.push_back(b[r*C +: C]);
        foreach (keep[i]) begin
            o[w*C +: C] = keep[i];
            w--;
        end
        return o;
    endfunction

    function automatic logic [N-1:0] rand_board(input int pfull);
        logic [N-1:0] b = '0;
        logic [C-1:0] row;
        for (int r = 0; r < R; r++) begin
            row = C'($urandom);
            if (int'($urandom_range(0, 99)) < pfull) row = '1;
            else if (&row) row[0] = 1'b0;
            b[r*C +: C] = row;
        end
        return b;
    endfunction

    task automatic run_op(input logic [N-1:0] b, input bit use2, input logic [N-1:0] b2,
                          output logic [N-1:0] ob, output logic [4:0] ol, output int dcyc,
                          output int exp_dcyc, output int fb, output int bb, output logic da);
        int k = model_full_cnt(b);
        int tc = 0;
        int t = -1;
        logic [N-1:0] fm = model_full_bits(b);
        logic [N-1:0] prev = board_out;
        logic [N-1:0] ef;
        fb = 0; bb = 0; dcyc = -1; ob = 'x; ol = 'x;
        board_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; board_in = rand_board(30);
        for (int c = 0; c < 3000; c++) begin
            if (done === 1'b1) begin
                dcyc = c; ob = board_out; ol = lines_cleared;
                break;
            end
            if (busy !== 1'b1) bb++;
            if (board_out !== prev) bb++;
            ef = (k > 0 && c >= 1 && tc < 30 && (tc / 5) % 2 == 0) ? fm : '0;
            if (flash !== ef) fb++;
            frame_tick = (c != 1) && ($urandom_range(0, 2) == 0);
            if (frame_tick && k > 0 && c >= 2 && tc < 30) begin
                tc++;
                if (tc == 30) t = c;
            end
            if (use2 && c == 5) begin
                start = 1'b1; board_in = b2;
            end
            @(posedge clk); #1;
            start = 1'b0; frame_tick = 1'b0;
        end
        exp_dcyc = (k == 0) ? 2 : t + 22 + k;
        @(posedge clk); #1;
        da = done;
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b0; frame_tick = 1'b0; board_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        if (flash !== '0) begin bad++; $display("FAIL reset flash: got %h want 0", flash); end
        if (board_out !== '0) begin bad++; $display("FAIL reset board_out: got %h want 0", board_out); end
        if (lines_cleared !== 5'd0) begin bad++; $display("FAIL reset lines: got %0d want 0", lines_cleared); end
        clr = 1'b0;
    endtask

    task automatic test_scenario(input string nm, input logic [N-1:0] b, input bit use2,
                                 input logic [N-1:0] b2);
        logic [N-1:0] ob, eb;
        logic [4:0]   ol;
        int           dcyc, ed, fb, bb;
        logic         da;
        eb = model_collapse(b);
        run_op(b, use2, b2, ob, ol, dcyc, ed, fb, bb, da);
        total += 6;
        if (dcyc !== ed) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, dcyc, ed); end
        if (ob !== eb) begin bad++; $display("FAIL %s board_out: got %h want %h", nm, ob, eb); end
        if (ol !== 5'(model_full_cnt(b))) begin bad++; $display("FAIL %s lines: got %0d want %0d", nm, ol, model_full_cnt(b)); end
        if (fb !== 0) begin bad++; $display("FAIL %s flash: got %0d wrong cycles want 0", nm, fb); end
        if (bb !== 0) begin bad++; $display("FAIL %s busy/hold: got %0d wrong cycles want 0", nm, bb); end
        if (da !== 1'b0) begin bad++; $display("FAIL %s done pulse width: got %b want 0 next cycle", nm, da); end
    endtask

    task automatic test_no_full;
        test_scenario("no_full", rand_board(0), 1'b0, '0);
    endtask

    task automatic test_single_row;
        logic [N-1:0] b = '0;
        b[199:190] = '1; b[183] = 1'b1;
        test_scenario("single", b, 1'b0, '0);
    endtask

    task automatic test_tetris;
        logic [N-1:0] b = '0;
        b[199:160] = '1; b[150] = 1'b1;
        test_scenario("tetris", b, 1'b0, '0);
    endtask

    task automatic test_split_rows;
        logic [N-1:0] b = '0;
        b[109:100] = '1; b[199:190] = '1; b[95] = 1'b1; b[185] = 1'b1;
        test_scenario("split", b, 1'b0, '0);
    endtask

    task automatic test_start_ignored;
        logic [N-1:0] b = '0;
        logic [N-1:0] b2 = '0;
        b[199:190] = '1; b[183] = 1'b1;
        b2[199:160] = '1; b2[150] = 1'b1;
        test_scenario("ignored_start", b, 1'b1, b2);
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) test_scenario($sformatf("random%0d", i), rand_board(25), 1'b0, '0);
    endtask

    task automatic test_clr_mid;
        logic [N-1:0] b = rand_board(0);
        b[199:190] = '1;
        for (int p = 0; p < 2; p++) begin
            board_in = b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            frame_tick = (p == 1);
            repeat (p == 0 ? 8 : 40) begin @(posedge clk); #1; end
            frame_tick = 1'b0; clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            total += 5;
            if (busy !== 1'b0) begin bad++; $display("FAIL clr%0d busy: got %b want 0", p, busy); end
            if (done !== 1'b0) begin bad++; $display("FAIL clr%0d done: got %b want 0", p, done); end
            if (flash !== '0) begin bad++; $display("FAIL clr%0d flash: got %h want 0", p, flash); end
            if (board_out !== '0) begin bad++; $display("FAIL clr%0d board_out: got %h want 0", p, board_out); end
            if (lines_cleared !== 5'd0) begin bad++; $display("FAIL clr%0d lines: got %0d want 0", p, lines_cleared); end
        end
        test_scenario("after_clr", b, 1'b0, '0);
    endtask

    task automatic test_back_to_back;
        test_scenario("b2b_a", rand_board(20), 1'b0, '0);
        test_scenario("b2b_b", rand_board(0), 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_no_full();
        test_single_row();
        test_tetris();
        test_split_rows();
        test_start_ignored();
        test_random();
        test_clr_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
